// File: rtl/rx_pkt_fifo29.sv
// Packet-commit receive buffer behind the GMII deframer: words become readable only once
// their packet completes, and a packet that runs out of space is rolled back whole.
module rx_pkt_fifo29 #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 29
) (
  input  logic                  clk125,
  input  logic                  sys_rst,
  input  logic [WIDTH-1:0]      datain,
  input  logic                  recv_en,
  input  logic                  packet_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   committed_cnt,
  output logic                  overflow,
  output logic [15:0]           pkt_drop_cnt
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   commit_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [WIDTH-1:0]   dout_r;
  logic               dout_valid_r;
  logic               empty_r;
  logic [PTR_W-1:0]   committed_cnt_r;
  logic               overflow_r;
  logic [15:0]        pkt_drop_cnt_r;

  logic [PTR_W-1:0]   fill_s;
  logic               space_ok_s;
  logic               accept_s;
  logic               wr_go_s;
  logic               drop_s;
  logic               commit_s;
  logic               do_read_s;
  logic [PTR_W-1:0]   commit_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;

  // Occupancy counts uncommitted words too; the read pointer is the registered one, so a
  // read in this cycle only frees its slot from the next cycle on.
  assign fill_s     = wr_ptr_r - rd_ptr_r;
  assign space_ok_s = (fill_s < DEPTH_P);
  assign accept_s   = (state_r != ST_DROP) && packet_en && recv_en;
  assign wr_go_s    = accept_s && space_ok_s;
  assign drop_s     = accept_s && !space_ok_s;
  assign commit_s   = (state_r == ST_RECV) && !packet_en;
  assign do_read_s  = rd_en && !empty_r;

  // Next commit/read pointers, shared by the FSM and the registered status outputs
  always_comb begin
    commit_ptr_nxt_s = commit_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    if (commit_s) begin
      commit_ptr_nxt_s = wr_ptr_r;
    end else begin
      commit_ptr_nxt_s = commit_ptr_r;
    end
    if (do_read_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Buffer write port, kept reset-free so it maps onto block RAM
  always_ff @(posedge clk125) begin
    if (wr_go_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= datain;
    end
  end

  // Packet FSM, pointers, read port and all registered outputs
  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      state_r         <= ST_IDLE;
      wr_ptr_r        <= '0;
      commit_ptr_r    <= '0;
      rd_ptr_r        <= '0;
      dout_r          <= '0;
      dout_valid_r    <= 1'b0;
      empty_r         <= 1'b1;
      committed_cnt_r <= '0;
      overflow_r      <= 1'b0;
      pkt_drop_cnt_r  <= 16'd0;
    end else begin
      commit_ptr_r    <= commit_ptr_nxt_s;
      rd_ptr_r        <= rd_ptr_nxt_s;
      empty_r         <= (rd_ptr_nxt_s == commit_ptr_nxt_s);
      committed_cnt_r <= commit_ptr_nxt_s - rd_ptr_nxt_s;
      dout_valid_r    <= do_read_s;
      overflow_r      <= drop_s;
      if (do_read_s) begin
        dout_r <= mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
      end
      if (drop_s && (pkt_drop_cnt_r != 16'hFFFF)) begin
        pkt_drop_cnt_r <= pkt_drop_cnt_r + 16'd1;
      end
      // Rolling back to the commit point discards every word of the offending packet
      if (drop_s) begin
        wr_ptr_r <= commit_ptr_r;
      end else if (wr_go_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case (state_r)
        ST_IDLE: begin
          if (packet_en) begin
            state_r <= drop_s ? ST_DROP : ST_RECV;
          end
        end
        ST_RECV: begin
          if (!packet_en) begin
            state_r <= ST_IDLE;
          end else if (drop_s) begin
            state_r <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (!packet_en) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout          = dout_r;
  assign dout_valid    = dout_valid_r;
  assign empty         = empty_r;
  assign committed_cnt = committed_cnt_r;
  assign overflow      = overflow_r;
  assign pkt_drop_cnt  = pkt_drop_cnt_r;

endmodule

// File: tb/tb_rx_pkt_fifo29.sv
// Bench for rx_pkt_fifo29 (16-word buffer): directed scenarios plus a random packet phase,
// all outputs compared every cycle against a queue-based packet model.
module tb_rx_pkt_fifo29;

  localparam int DL2   = 4;
  localparam int W     = 29;
  localparam int DEPTH = 1 << DL2;

  logic           clk125;
  logic           sys_rst;
  logic [W-1:0]   datain;
  logic           recv_en;
  logic           packet_en;
  logic           rd_en;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           empty;
  logic [DL2:0]   committed_cnt;
  logic           overflow;
  logic [15:0]    pkt_drop_cnt;

  rx_pkt_fifo29 #(.DEPTH_LOG2(DL2), .WIDTH(W)) dut (
    .clk125        (clk125),
    .sys_rst       (sys_rst),
    .datain        (datain),
    .recv_en       (recv_en),
    .packet_en     (packet_en),
    .rd_en         (rd_en),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .empty         (empty),
    .committed_cnt (committed_cnt),
    .overflow      (overflow),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: committed-unread words, words of the packet in progress
  logic [W-1:0] cq[$];
  logic [W-1:0] pq[$];
  bit           m_dropping = 1'b0;
  logic [W-1:0] m_dout     = '0;
  bit           m_valid    = 1'b0;
  bit           m_ovf      = 1'b0;
  int           m_drops    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    int occ;
    if (sys_rst) begin
      cq.delete(); pq.delete();
      m_dropping = 1'b0; m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_drops = 0;
    end else begin
      occ     = cq.size() + pq.size();
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      if (rd_en && cq.size() > 0) begin
        m_dout  = cq.pop_front();
        m_valid = 1'b1;
      end
      if (packet_en) begin
        if (recv_en && !m_dropping) begin
          if (occ < DEPTH) begin
            pq.push_back(datain);
          end else begin
            pq.delete();
            m_dropping = 1'b1;
            m_ovf      = 1'b1;
            if (m_drops < 65535) m_drops++;
          end
        end
      end else begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
        m_dropping = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("dout", 32'(dout), 32'(m_dout));
    check("empty", 32'(empty), 32'(cq.size() == 0));
    check("committed_cnt", 32'(committed_cnt), 32'(cq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("pkt_drop_cnt", 32'(pkt_drop_cnt), 32'(m_drops));
  endtask

  task automatic step(input bit rst, input bit pe, input bit re, input logic [W-1:0] d, input bit rd);
    sys_rst = rst; packet_en = pe; recv_en = re; datain = d; rd_en = rd;
    @(posedge clk125);
    model_edge();
    @(negedge clk125);
    check_outputs();
  endtask

  task automatic send_pkt(input logic [W-1:0] base, input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, base + W'(i), rd);
    step(1'b0, 1'b0, 1'b0, '0, rd);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    sys_rst = 1'b1; packet_en = 1'b0; recv_en = 1'b0; datain = '0; rd_en = 1'b0;
    // Reset values
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Single packet 1..4, then read out
    send_pkt(W'(1), 4, 1'b0);
    reads(5);

    // Overflow: 20-word packet dropped, following 3-word packet commits
    send_pkt(W'('h200), 20, 1'b0);
    check("drop_after_20", 32'(pkt_drop_cnt), 32'd1);
    send_pkt(W'('h300), 3, 1'b0);
    check("cnt_after_3", 32'(committed_cnt), 32'd3);
    reads(4);

    // Ignored input: recv_en without packet, empty packet, reads while empty
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, W'('h55 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Concurrent read of one packet while the next arrives
    send_pkt(W'('h10), 8, 1'b0);
    send_pkt(W'('h100), 8, 1'b1);
    reads(9);

    // Wrap-around: 5 packets of 10 words, each drained
    for (int p = 0; p < 5; p++) begin
      send_pkt(W'('h400 + 16 * p), 10, 1'b0);
      reads(11);
    end

    // Reset mid-packet, packet_en stays high afterwards
    send_pkt(W'('h500), 5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, W'('h600 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, W'('h603), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, W'('h700 + i), 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    reads(3);

    // Random packets, gaps and reads
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++)
        step(1'b0, 1'b1, ($urandom % 4) != 0, W'($urandom), ($urandom % 3) == 0);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        step(1'b0, 1'b0, ($urandom % 2) == 0, W'($urandom), ($urandom % 2) == 0);
    end
    reads(DEPTH + 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx_pkt_fifo29.md
# rx_pkt_fifo29

Packet-commit receive buffer directly downstream of `gmii2fifo24` in the GMII receive path. It stores the 29-bit words that the deframer produces (`datain` qualified by `recv_en`) only while `packet_en` frames a packet. A packet becomes visible to the reader only when it completes. A packet that overflows the buffer is rolled back in full, so the pixel/line logic downstream never sees a truncated packet.

## Interface
- `DEPTH_LOG2`, 10, log2 of buffer depth in words (DEPTH = 2^DEPTH_LOG2)
- `WIDTH`, 29, word width; matches `datain` of `gmii2fifo24`
- `clk125`  in  1  125 MHz GMII receive clock; the only clock
- `sys_rst`  in  1  reset, synchronous, active-high
- `datain`  in  WIDTH  word from deframer
- `recv_en`  in  1  `datain` valid this cycle
- `packet_en`  in  1  high for the duration of an accepted packet; falling edge ends the packet
- `rd_en`  in  1  read request
- `dout`  out  WIDTH  read data, registered
- `dout_valid`  out  1  `dout` holds a newly read word this cycle
- `empty`  out  1  no committed words available
- `committed_cnt`  out  DEPTH_LOG2+1  committed, unread words
- `overflow`  out  1  one-cycle pulse when a packet is dropped for lack of space
- `pkt_drop_cnt`  out  16  count of dropped packets, saturating at 0xFFFF

## Operation
- Pointers `wr_ptr` (speculative), `commit_ptr` and `rd_ptr` are each DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
- Buffer memory is DEPTH x WIDTH, single write port and single read port, inferable as block RAM.
- State machine: IDLE, RECV, DROP.
- IDLE:
  - `packet_en`=1 -> RECV.
  - A `recv_en` in the same cycle is processed exactly as in RECV.
  - `recv_en` while `packet_en`=0 is ignored.
- RECV, on a cycle with `recv_en`=1 and `packet_en`=1:
  - If (`wr_ptr` - `rd_ptr`) < DEPTH: write the word at `wr_ptr`, then `wr_ptr`+1.
  - Otherwise: `wr_ptr` <= `commit_ptr`, pulse `overflow`, `pkt_drop_cnt`+1 (saturating), go to DROP.
- RECV, `packet_en`=0: `commit_ptr` <= `wr_ptr`, go to IDLE. A zero-length packet commits nothing.
- DROP:
  - All input is ignored while `packet_en`=1.
  - `packet_en`=0 -> IDLE.
  - Nothing is committed.
- Read side:
  - `rd_en`=1 and `empty`=0: read the word at `rd_ptr`, then `rd_ptr`+1.
  - `rd_en` while `empty`=1 is ignored, with no pointer change and no `dout_valid`.
- `empty` = (`rd_ptr` == `commit_ptr`).
- `committed_cnt` = `commit_ptr` - `rd_ptr`, modulo 2^(DEPTH_LOG2+1).
- Space check uses the registered `rd_ptr`. A read in the same cycle does not free space until the next cycle (conservative).
- A write and a read in the same cycle are both performed. Read and write addresses never collide, because reads stop at `commit_ptr`.
- A packet larger than DEPTH can never be accepted; it is always dropped.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `empty`=1, `committed_cnt`=0, `overflow`=0, `pkt_drop_cnt`=0, all pointers 0, state IDLE.
- Reset mid-packet discards all buffered data, committed or not.
- Write latency: a word sampled at edge N is in memory after edge N.
- Commit latency: if `packet_en`=0 is sampled at edge M, `commit_ptr` updates at M. `empty`/`committed_cnt` reflect the new packet in the cycle after edge M.
- Read latency: 1 cycle. `rd_en` sampled at edge K drives `dout`/`dout_valid` valid after edge K, for one cycle.
  - `dout` holds its value when no read occurs.
  - Back-to-back `rd_en` gives one word per cycle.
- `overflow` is high for exactly the one cycle after the offending `recv_en` edge.
- Pointer wrap is handled purely by modulo arithmetic; no special case at the DEPTH boundary.

## Test plan
- Single packet:
  - Stimulus: 4 words 0x0000001..0x0000004, `packet_en` high for 4 `recv_en` cycles, then low; then `rd_en` for 4 cycles.
  - Required: `empty`=1 throughout the packet; `empty`=0 and `committed_cnt`=4 one cycle after `packet_en` falls; `dout` = 1,2,3,4 with `dout_valid`, each one cycle after its `rd_en`; then `empty`=1.
- Overflow (DEPTH_LOG2=4):
  - Stimulus: 20-word packet with no reads, followed by a 3-word packet.
  - Required: `overflow` pulses after the 17th word; `pkt_drop_cnt`=1; `committed_cnt`=0; `empty` stays 1. The following 3-word packet commits with `committed_cnt`=3.
- Ignored input:
  - Stimulus: `recv_en` pulses with `packet_en`=0; a `packet_en` pulse with no `recv_en`; `rd_en` while empty.
  - Required: `committed_cnt`=0, `empty`=1, `dout_valid` never asserted.
- Concurrent read/write:
  - Stimulus: drain an 8-word packet with continuous `rd_en` while a second 8-word packet (0x100..0x107) arrives.
  - Required: first packet read intact and in order; second packet becomes visible only after its `packet_en` falls.
- Wrap-around (DEPTH_LOG2=4):
  - Stimulus: 5 packets of 10 words, each fully drained before the next arrives.
  - Required: all 50 words read out in order, no `overflow`, `committed_cnt` correct across the pointer wrap.
- Reset mid-packet:
  - Stimulus: commit a 5-word packet, start a second packet, then assert `sys_rst` for 1 cycle after 3 of its words.
  - Required: all outputs at reset values; words arriving afterwards while `packet_en` is still high are accepted as a new packet.
